data_mem: RTL and testbench
===========================

// Module: data_mem
// PURPOSE
//  Word-organised data memory for the MIPS datapath (MEM stage); services lw/sw.
//  Synchronous write on the rising clock edge and combinational (zero-latency) read, gated by memread.
//  The control unit drives memread and memwrite. The ALU result drives address.
//  readdata feeds the write-back mux.
// PARAMETERS
//  DATA_WIDTH   32   width of each memory word and of the data ports
//  ADDR_WIDTH   32   width of the address port
//  DEPTH        256  number of words; power of two, at least 2
//  IDX_W        8    log2(DEPTH); the low IDX_W address bits select the word
// PORTS
//  clk        in   1           system clock; all writes happen on its rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  address    in   ADDR_WIDTH  word index; only address[IDX_W-1:0] is used
//  writeData  in   DATA_WIDTH  data to store when memwrite=1
//  memwrite   in   1           write enable
//  memread    in   1           read enable
//  readdata   out  DATA_WIDTH  read data
// BEHAVIOUR
//  Clock and reset
//  - One clock; reset is asynchronous and active-low.
//  - While rst_n=0: every word is cleared to 0 immediately, readdata=0, and writes are ignored.
//  - First write after reset release: the first rising clk edge with rst_n=1 and memwrite=1.
//  Addressing
//  - Word index = address[IDX_W-1:0]; upper bits are ignored.
//  - Addresses beyond DEPTH-1 therefore wrap modulo DEPTH (e.g. DEPTH=256: 266 aliases 10).
//  - There is no byte addressing and no alignment check.
//  Write
//  - At posedge clk with rst_n=1 and memwrite=1: mem[idx] <= writeData.
//  - Latency is 1 edge; the written value is visible on readdata immediately after that edge.
//  Read
//  - Purely combinational: readdata = (rst_n && memread) ? mem[idx] : 0.
//  - readdata follows address and memread changes with no clock needed.
//  - memread=0 forces readdata to 0 (no stale data is held).
//  Simultaneous events
//  - memread=1 and memwrite=1 to the same index: before the edge, readdata shows the old word.
//    After the edge it shows writeData. The write always takes place.
//  - Reset asserted while a write is pending: reset wins and the memory stays all-zero.
//  Other rules
//  - memwrite=0 leaves the contents unchanged.
//  - No X may propagate to readdata after reset; all words start at 0.
// TESTING
//  1. rst_n=0 pulse, then memread=1 at addr 0, 10, 255 -> readdata=0 at each.
//  2. addr=10, writeData=200, memwrite=1, memread=0, one posedge -> readdata=0.
//     Then memwrite=0, memread=1 -> readdata=200.
//  3. After step 2, addr=0, memread=0 -> readdata=0.
//     Then memread=1, addr=0 -> 0; then addr=10 -> 200, with no clock edge in between.
//  4. memread=1, memwrite=1, addr=5, writeData=0xDEADBEEF:
//     before the edge readdata=0, after the edge readdata=0xDEADBEEF.
//  5. Write 0x12345678 to addr 266 (DEPTH=256), then read addr 10 -> 0x12345678 (wrap alias).
//  6. Write 7 to addr 3, assert rst_n=0 mid-cycle -> readdata=0 at once.
//     After release, read addr 3 -> 0.

Source files
------------

// File: rtl/data_mem.sv
// data_mem: word-organised data memory, synchronous write and combinational gated read.
module data_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  memwrite,
  input  logic                  memread,
  output logic [DATA_WIDTH-1:0] readdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  unused_addr;
  assign idx         = address[IDX_W-1:0];
  assign unused_addr = ^address[ADDR_WIDTH-1:IDX_W];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (memwrite) begin
      mem_q[idx] <= writeData;
    end
  end
  // Read is gated so nothing stale leaks out while disabled or in reset.
  assign readdata = (rst_n && memread) ? mem_q[idx] : '0;
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: table vectors, hand-written corner sequences and a random run against a word-array model.
module tb_data_mem;
  localparam int DEPTH = 256;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [31:0] readdata;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [DEPTH];

  data_mem dut (
    .clk(clk), .rst_n(rst_n), .address(address), .writeData(writeData),
    .memwrite(memwrite), .memread(memread), .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: readdata=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd);
    memwrite = we; memread = re; address = a; writeData = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'd10,          32'd200,        32'd0,        32'd0};
    tbl[1] = '{1'b0, 1'b1, 32'd10,          32'd0,          32'd200,      32'd200};
    tbl[2] = '{1'b0, 1'b0, 32'd0,           32'd0,          32'd0,        32'd0};
    tbl[3] = '{1'b0, 1'b1, 32'd0,           32'd0,          32'd0,        32'd0};
    tbl[4] = '{1'b0, 1'b1, 32'd10,          32'd0,          32'd200,      32'd200};
    tbl[5] = '{1'b1, 1'b1, 32'd5,           32'hDEADBEEF,   32'd0,        32'hDEADBEEF};
    tbl[6] = '{1'b1, 1'b0, 32'd266,         32'h12345678,   32'd0,        32'd0};
    tbl[7] = '{1'b0, 1'b1, 32'd10,          32'hFFFFFFFF,   32'h12345678, 32'h12345678};
    tbl[8] = '{1'b0, 1'b1, 32'd266,         32'd0,          32'h12345678, 32'h12345678};
    tbl[9] = '{1'b0, 1'b1, 32'hFFFF_FF05,   32'd0,          32'hDEADBEEF, 32'hDEADBEEF};

    // Reset state: forced zero during reset, cleared words after release
    drive(1'b0, 1'b1, 32'd0, 32'd0);
    #3;
    chk("in_reset_addr0", readdata, 32'd0);
    do_reset();
    foreach (tbl[i]) ;
    drive(1'b0, 1'b1, 32'd0, 32'd0);   #1 chk("reset_addr0", readdata, 32'd0);
    drive(1'b0, 1'b1, 32'd10, 32'd0);  #1 chk("reset_addr10", readdata, 32'd0);
    drive(1'b0, 1'b1, 32'd255, 32'd0); #1 chk("reset_addr255", readdata, 32'd0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wd);
      #1 chk($sformatf("tbl%0d_pre", i), readdata, tbl[i].exp_pre);
      @(posedge clk);
      #1 chk($sformatf("tbl%0d_post", i), readdata, tbl[i].exp_post);
    end

    // Combinational read follows address/memread with no clock edge
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd10, 32'd0); #1 chk("comb_rd_off", readdata, 32'd0);
    memread = 1'b1;                   #1 chk("comb_rd_on10", readdata, 32'h12345678);
    address = 32'd0;                  #1 chk("comb_addr0", readdata, 32'd0);
    address = 32'd5;                  #1 chk("comb_addr5", readdata, 32'hDEADBEEF);

    // Write then async reset mid-cycle with a write still pending
    @(negedge clk);
    drive(1'b1, 1'b1, 32'd3, 32'd7);
    @(posedge clk);
    #1 chk("wr3_post", readdata, 32'd7);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_now", readdata, 32'd0);
    @(posedge clk);
    #1 chk("rst_over_edge", readdata, 32'd0);
    @(negedge clk);
    memwrite = 1'b0;
    rst_n = 1'b1;
    #1 chk("post_rst_addr3", readdata, 32'd0);
    address = 32'd5;  #1 chk("post_rst_addr5", readdata, 32'd0);
    address = 32'd10; #1 chk("post_rst_addr10", readdata, 32'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Random traffic against the word-array model
    for (int n = 0; n < 400; n++) begin
      logic        we, re;
      logic [31:0] a, wd, exp;
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 3) != 0);
      a  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      wd = $urandom;
      drive(we, re, a, wd);
      exp = re ? ref_mem[a % DEPTH] : 32'd0;
      #1 chk($sformatf("rnd%0d_pre", n), readdata, exp);
      @(posedge clk);
      if (we) ref_mem[a % DEPTH] = wd;
      exp = re ? ref_mem[a % DEPTH] : 32'd0;
      #1 chk($sformatf("rnd%0d_post", n), readdata, exp);
    end

    // Final sweep of the whole array without clocking
    @(negedge clk);
    drive(1'b0, 1'b1, 32'd0, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      address = 32'(i) + 32'h0000_0100;
      #1 chk($sformatf("sweep%0d", i), readdata, ref_mem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
